// File: rtl/sample_streamer.sv
// Streams 16-bit samples from a looped RAM region, one word transfer per audio tick.
// Define SAMPLE_STREAMER_RECORD_EN to enable write (record) transfers.
module sample_streamer #(
   parameter int ADDR_W  = 23,
   parameter int TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              tick,
   input  logic              play,
   input  logic              record,
   input  logic [ADDR_W-1:0] loop_start,
   input  logic [ADDR_W-1:0] loop_end,
   input  logic [15:0]       rec_sample,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [15:0]       mem_wdata,
   input  logic [15:0]       mem_rdata,
   input  logic              mem_done,
   output logic [15:0]       sample_out,
   output logic              sample_valid,
   output logic              overrun,
   output logic              timeout_err
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_ARM  = 2'd1;
   localparam logic [1:0] S_XFER = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   localparam int               CNT_W    = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   logic [1:0]        state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              mem_req_q, mem_req_d;
   logic              mem_we_q, mem_we_d;
   logic [15:0]       mem_wdata_q, mem_wdata_d;
   logic [15:0]       sample_out_q, sample_out_d;
   logic              sample_valid_q, sample_valid_d;
   logic              overrun_q, overrun_d;
   logic              timeout_err_q, timeout_err_d;
   logic              play_prev_q;

   logic              wr_sel;
   logic [15:0]       wr_data;

`ifdef SAMPLE_STREAMER_RECORD_EN
   assign wr_sel  = record;
   assign wr_data = record ? rec_sample : 16'h0000;
`else
   // Playback-only build: record inputs are deliberately left unused.
   logic unused_rec;
   assign unused_rec = ^{record, rec_sample};
   assign wr_sel     = 1'b0;
   assign wr_data    = 16'h0000;
`endif

   always_comb begin
      // NOTE: every _d gets a default first so no path through the case infers a latch.
      state_d        = state_q;
      addr_d         = addr_q;
      cnt_d          = cnt_q;
      mem_req_d      = mem_req_q;
      mem_we_d       = mem_we_q;
      mem_wdata_d    = mem_wdata_q;
      sample_out_d   = sample_out_q;
      sample_valid_d = 1'b0;
      overrun_d      = overrun_q;
      timeout_err_d  = timeout_err_q;

      case (state_q)
         S_IDLE: begin
            if (play && !play_prev_q) begin
               addr_d  = loop_start;
               state_d = S_ARM;
            end
         end
         S_ARM: begin
            if (!play) begin
               state_d = S_IDLE;
            end else if (tick) begin
               state_d     = S_XFER;
               cnt_d       = '0;
               mem_req_d   = 1'b1;
               mem_we_d    = wr_sel;
               mem_wdata_d = wr_data;
            end
         end
         S_XFER: begin
            if (tick) overrun_d = 1'b1;
            // A completion in the final counted cycle still wins over the abort.
            if (mem_done) begin
               state_d   = S_DONE;
               mem_req_d = 1'b0;
               if (!mem_we_q) begin
                  sample_out_d   = mem_rdata;
                  sample_valid_d = 1'b1;
               end
            end else if (cnt_q == CNT_LAST) begin
               state_d       = S_DONE;
               mem_req_d     = 1'b0;
               timeout_err_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_DONE: begin
            if (tick) overrun_d = 1'b1;
            addr_d  = (addr_q >= loop_end) ? loop_start : addr_q + 1'b1;
            state_d = play ? S_ARM : S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments only.
      if (rst) begin
         state_q        <= S_IDLE;
         addr_q         <= '0;
         cnt_q          <= '0;
         mem_req_q      <= 1'b0;
         mem_we_q       <= 1'b0;
         mem_wdata_q    <= 16'h0000;
         sample_out_q   <= 16'h0000;
         sample_valid_q <= 1'b0;
         overrun_q      <= 1'b0;
         timeout_err_q  <= 1'b0;
         play_prev_q    <= 1'b0;
      end else begin
         state_q        <= state_d;
         addr_q         <= addr_d;
         cnt_q          <= cnt_d;
         mem_req_q      <= mem_req_d;
         mem_we_q       <= mem_we_d;
         mem_wdata_q    <= mem_wdata_d;
         sample_out_q   <= sample_out_d;
         sample_valid_q <= sample_valid_d;
         overrun_q      <= overrun_d;
         timeout_err_q  <= timeout_err_d;
         play_prev_q    <= play;
      end
   end

   // The word pointer only moves outside XFER, so it doubles as the request address.
   assign mem_addr     = addr_q;
   assign mem_req      = mem_req_q;
   assign mem_we       = mem_we_q;
   assign mem_wdata    = mem_wdata_q;
   assign sample_out   = sample_out_q;
   assign sample_valid = sample_valid_q;
   assign overrun      = overrun_q;
   assign timeout_err  = timeout_err_q;

endmodule

// File: tb/tb_sample_streamer.sv
// Randomized self-checking bench for sample_streamer against a transaction-level model.
module tb_sample_streamer;

   localparam int ADDR_W  = 23;
   localparam int TIMEOUT = 15;

   logic              clk = 1'b0;
   logic              rst, tick, play, record, mem_done;
   logic [ADDR_W-1:0] loop_start, loop_end;
   logic [15:0]       rec_sample, mem_rdata;
   logic              mem_req, mem_we, sample_valid, overrun, timeout_err;
   logic [ADDR_W-1:0] mem_addr;
   logic [15:0]       mem_wdata, sample_out;

   int n_checks = 0;
   int n_pass   = 0;

   // Model state: programmed loop region, next word, last sample, sticky flags.
   logic [ADDR_W-1:0] reg_start, reg_end, exp_addr;
   logic [15:0]       exp_sample;
   logic              exp_overrun, exp_tout;

   sample_streamer #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst), .tick(tick), .play(play), .record(record),
      .loop_start(loop_start), .loop_end(loop_end), .rec_sample(rec_sample),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_done(mem_done), .sample_out(sample_out),
      .sample_valid(sample_valid), .overrun(overrun), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
      return (a >= reg_end) ? reg_start : a + 1'b1;
   endfunction

   task automatic start_play(input logic [ADDR_W-1:0] s, input logic [ADDR_W-1:0] e);
      play = 1'b0; tick = 1'b0;
      @(negedge clk);
      reg_start = s; reg_end = e;
      loop_start = s; loop_end = e;
      play = 1'b1;
      @(negedge clk);
      exp_addr = s;
   endtask

   task automatic arm_wait(input int n);
      int seen = 0;
      tick = 1'b0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (mem_req) seen++;
      end
      check("arm_hold_no_req", seen, 0);
   endtask

   // One tick-started transfer. d = done delay after request (0: never),
   // tick2_at / play_low_at = cycle offset into the transfer, -1 to disable.
   task automatic xfer(input int d, input int tick2_at, input int play_low_at,
                       input logic rec, input logic [15:0] rsamp);
      int          high, valid_cnt, e;
      bit          stable;
      logic        exp_we;
      logic [15:0] exp_wd, rdata;
      rdata = 16'($urandom);
      record = rec; rec_sample = rsamp;
`ifdef SAMPLE_STREAMER_RECORD_EN
      exp_we = rec;
`else
      exp_we = 1'b0;
`endif
      exp_wd = exp_we ? rsamp : 16'h0000;
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
      check("req_latency", mem_req, 1);
      check("mem_addr", mem_addr, exp_addr);
      check("mem_we", mem_we, exp_we);
      check("mem_wdata", mem_wdata, exp_wd);
      // Disturb inputs that must not reach an in-flight request.
      loop_start = ADDR_W'($urandom); loop_end = ADDR_W'($urandom);
      record = ~record; rec_sample = ~rec_sample;
      high = 0; valid_cnt = 0; stable = 1'b1; e = -1;
      for (int i = 0; i < 40; i++) begin
         if (sample_valid) valid_cnt++;
         if (!mem_req) begin
            e = i;
            break;
         end
         high++;
         if (mem_addr !== exp_addr || mem_we !== exp_we || mem_wdata !== exp_wd) stable = 1'b0;
         tick = (i == tick2_at);
         if (i == play_low_at) play = 1'b0;
         mem_done  = (d > 0 && i == d - 1);
         mem_rdata = mem_done ? rdata : 16'($urandom);
         @(negedge clk);
      end
      mem_done = 1'b0;
      loop_start = reg_start; loop_end = reg_end;
      tick = (e >= 0 && tick2_at == e);
      @(negedge clk);
      tick = 1'b0;
      if (sample_valid) valid_cnt++;

      if (tick2_at >= 0) exp_overrun = 1'b1;
      if (d == 0) exp_tout = 1'b1;
      else if (!exp_we) exp_sample = rdata;

      check("req_after_done", mem_req, 0);
      check("req_dwell", high, (d > 0) ? d : TIMEOUT);
      check("sample_valid_pulses", valid_cnt, (d > 0 && !exp_we) ? 1 : 0);
      check("req_fields_stable", stable, 1);
      check("sample_out", sample_out, exp_sample);
      check("overrun", overrun, exp_overrun);
      check("timeout_err", timeout_err, exp_tout);
      exp_addr = next_addr(exp_addr);
   endtask

   task automatic no_req_ticks(input int n);
      int seen = 0;
      for (int i = 0; i < n; i++) begin
         tick = 1'b1;
         @(negedge clk);
         tick = 1'b0;
         if (mem_req) seen++;
         @(negedge clk);
         if (mem_req) seen++;
      end
      check("idle_no_req", seen, 0);
   endtask

   initial begin
      int d, t2, ee;
      rst = 1'b1; tick = 1'b0; play = 1'b0; record = 1'b0; mem_done = 1'b0;
      loop_start = '0; loop_end = '0; rec_sample = '0; mem_rdata = '0;
      reg_start = '0; reg_end = '0; exp_addr = '0;
      exp_sample = '0; exp_overrun = 1'b0; exp_tout = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_mem_req", mem_req, 0);
      check("rst_mem_we", mem_we, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_mem_wdata", mem_wdata, 0);
      check("rst_sample_out", sample_out, 0);
      check("rst_sample_valid", sample_valid, 0);
      check("rst_overrun", overrun, 0);
      check("rst_timeout_err", timeout_err, 0);
      rst = 1'b0;

      // Loop 4..6 over five ticks: addresses 4,5,6,4,5.
      start_play(23'd4, 23'd6);
      arm_wait(3);
      for (int k = 0; k < 5; k++) xfer(6, -1, -1, 1'b0, 16'h0000);

      xfer(6, 1, -1, 1'b0, 16'h0000);   // second tick two cycles in
      xfer(5, 4, -1, 1'b0, 16'h0000);   // tick together with mem_done
      xfer(3, 3, -1, 1'b0, 16'h0000);   // tick during DONE
      xfer(15, -1, -1, 1'b0, 16'h0000); // done on the last allowed cycle
      xfer(0, -1, -1, 1'b0, 16'h0000);  // no done: abort
      xfer(4, -1, -1, 1'b0, 16'h0000);  // next address after abort
      xfer(4, -1, -1, 1'b1, 16'hA5A5);  // record request (write only in record builds)

      xfer(6, -1, 2, 1'b0, 16'h0000);   // play drops mid-transfer
      no_req_ticks(3);

      // Degenerate and single-word regions.
      start_play(23'd10, 23'd3);
      for (int k = 0; k < 3; k++) xfer(2, -1, -1, 1'b0, 16'h0000);
      start_play(23'd7, 23'd7);
      for (int k = 0; k < 2; k++) xfer(1, -1, -1, 1'b0, 16'h0000);

      // Random regions, gaps, delays and stray ticks.
      for (int r = 0; r < 6; r++) begin
         start_play(ADDR_W'($urandom_range(0, 30)), ADDR_W'($urandom_range(0, 30)));
         arm_wait($urandom_range(0, 3));
         for (int k = 0; k < 4; k++) begin
            d  = ($urandom_range(0, 6) == 0) ? 0 : int'($urandom_range(1, 15));
            ee = (d > 0) ? d : TIMEOUT;
            t2 = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, ee)) : -1;
            xfer(d, t2, -1, 1'($urandom), 16'($urandom));
         end
      end

      // Reset two cycles into a transfer abandons it.
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
      check("pre_rst_req", mem_req, 1);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("midrst_mem_req", mem_req, 0);
      check("midrst_mem_addr", mem_addr, 0);
      check("midrst_sample_out", sample_out, 0);
      check("midrst_overrun", overrun, 0);
      check("midrst_timeout_err", timeout_err, 0);
      rst = 1'b0; play = 1'b0;
      mem_done = 1'b1; mem_rdata = 16'hBEEF;
      @(negedge clk);
      mem_done = 1'b0;
      @(negedge clk);
      check("abandoned_no_valid", sample_valid, 0);
      check("abandoned_sample_out", sample_out, 0);
      exp_sample = '0; exp_overrun = 1'b0; exp_tout = 1'b0;

      start_play(23'd100, 23'd101);
      for (int k = 0; k < 3; k++) xfer(3, -1, -1, 1'b0, 16'h0000);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/sample_streamer.md
SAMPLE_STREAMER -- requirements
Module: sample_streamer

Interface
REQ-001 Parameter ADDR_W, 23, RAM word-address width.
REQ-002 Parameter TIMEOUT, 15, max clk cycles from request issue to mem_done before abort.
REQ-003 clk  input  1  system clock; all logic on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 tick  input  1  one-cycle audio-rate strobe (31.5 kHz) starting one sample transfer.
REQ-006 play  input  1  level; high enables streaming.
REQ-007 record  input  1  level; selects write transfers (RECORD_EN builds only).
REQ-008 loop_start  input  ADDR_W  first address of loop region.
REQ-009 loop_end  input  ADDR_W  last address of loop region.
REQ-010 rec_sample  input  16  sample written when recording.
REQ-011 mem_req  output  1  transfer request to RAM controller.
REQ-012 mem_we  output  1  1 = write, 0 = read; valid while mem_req high.
REQ-013 mem_addr  output  ADDR_W  transfer address; valid while mem_req high.
REQ-014 mem_wdata  output  16  write data; valid while mem_req high.
REQ-015 mem_rdata  input  16  read data, valid in the cycle mem_done is high.
REQ-016 mem_done  input  1  one-cycle completion pulse from RAM controller.
REQ-017 sample_out  output  16  last sample read.
REQ-018 sample_valid  output  1  one-cycle pulse when sample_out updates.
REQ-019 overrun  output  1  sticky: tick arrived while busy.
REQ-020 timeout_err  output  1  sticky: transfer aborted by timeout.

Function
REQ-021 FSM states IDLE, ARM, XFER, DONE; any unused encoding returns to IDLE next cycle.
REQ-022 IDLE: on play rising edge (play high, previous-cycle play low), load addr <= loop_start, go ARM.
REQ-023 ARM: tick with play high -> XFER next cycle; play low -> IDLE; no tick -> stay.
REQ-024 XFER: mem_req high; mem_we, mem_addr, mem_wdata held stable for the whole XFER dwell; timeout counter increments each cycle.
REQ-025 XFER: mem_done -> DONE; if read, sample_out <= mem_rdata on that edge and sample_valid high the following cycle.
REQ-026 XFER: counter reaching TIMEOUT without mem_done -> drop mem_req, set timeout_err, go DONE; sample_out unchanged; no sample_valid.
REQ-027 DONE (one cycle): advance address, then ARM if play high else IDLE; mem_req low.
REQ-028 Address advance: addr >= loop_end -> addr <= loop_start; otherwise addr + 1 (covers loop_end < loop_start: region degenerates to the single word loop_start).
REQ-029 tick in XFER or DONE: tick discarded, overrun set; ticks are never queued.
REQ-030 Simultaneous tick and mem_done: transfer completes normally, tick discarded, overrun set.
REQ-031 play falling during XFER: transfer still runs to mem_done or timeout, results reported normally, then IDLE.
REQ-032 loop_start/loop_end sampled only on load (REQ-022) and wrap (REQ-028); changes mid-transfer do not alter mem_addr.
REQ-033 overrun and timeout_err clear only on rst.
REQ-034 Latency: tick in ARM -> mem_req high 1 cycle later; mem_done -> sample_valid 1 cycle later.

Reset
REQ-035 rst high at a clk edge: state IDLE, addr 0, timeout counter 0, mem_req 0, mem_we 0, mem_addr 0, mem_wdata 0, sample_out 0, sample_valid 0, overrun 0, timeout_err 0, previous-play register 0.
REQ-036 rst during XFER drops mem_req the next edge; the in-flight transfer is abandoned with no sample_valid.

Configuration
REQ-037 SAMPLE_STREAMER_RECORD_EN defined: record high at the ARM->XFER transition makes the transfer a write (mem_we 1, mem_wdata = rec_sample captured on that edge); write completion produces no sample_valid and leaves sample_out unchanged.
REQ-038 SAMPLE_STREAMER_RECORD_EN undefined: record and rec_sample ignored; mem_we and mem_wdata constant 0.

Verification
REQ-039 loop_start=4, loop_end=6, play, 5 ticks, mem_done 6 cycles after each req -> mem_addr sequence 4,5,6,4,5; one sample_valid per tick with matching mem_rdata.
REQ-040 Tick again 2 cycles after a tick, mem_done 6 cycles after req -> second tick ignored, overrun=1, only one mem_req.
REQ-041 mem_done never asserted -> mem_req falls after 15 cycles high, timeout_err=1, no sample_valid, next tick reads the next address.
REQ-042 play low 2 cycles into XFER, then mem_done -> sample_valid pulses once, FSM IDLE, no further mem_req on later ticks.
REQ-043 rst asserted mid-XFER -> all outputs 0 next cycle, flags cleared.
REQ-044 RECORD_EN build, record=1, rec_sample=16'hA5A5, tick -> mem_we=1, mem_wdata=16'hA5A5, no sample_valid on done.
